// File: rtl/store_buffer.sv
// MEM-stage store buffer: aligns SB/SH/SW stores and queues them
// in a small FIFO that drains to the data memory write port.
module store_buffer #(
  parameter int BITS_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_store_valid,
  input  logic [1:0]           i_store_type,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [BITS_SIZE-1:0] i_data,
  output logic                 o_store_ready,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic                 o_empty,
  output logic                 o_mem_we,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [BITS_SIZE-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_be,
  input  logic                 i_mem_ack
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [BITS_SIZE-1:0] wdata;
    logic [3:0]           be;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  entry_t     al;
  logic       legal;
  logic       enq;
  logic       deq;
  logic [1:0] a;

  assign a = i_addr[1:0];

  always_comb begin
    al       = '0;
    legal    = 1'b0;
    al.addr  = {i_addr[ADDR_SIZE-1:2], 2'b00};
    unique case (1'b1)
      (i_store_type == ST_SB): begin
        legal    = 1'b1;
        al.be    = 4'b0001 << a;
        al.wdata = {4{i_data[7:0]}};
      end
      (i_store_type == ST_SH): begin
        legal    = ~a[0];
        al.be    = a[1] ? 4'b1100 : 4'b0011;
        al.wdata = {2{i_data[15:0]}};
      end
      (i_store_type == ST_SW): begin
        legal    = (a == 2'b00);
        al.be    = 4'b1111;
        al.wdata = i_data;
      end
      default: legal = 1'b0;
    endcase
  end

  assign o_store_ready = (count != FULL);
  assign o_stall       = i_store_valid & ~o_store_ready;
  assign o_empty       = (count == '0);
  assign o_mem_we      = ~o_empty;

  assign enq = i_store_valid & o_store_ready & legal;
  assign deq = o_mem_we & i_mem_ack;

  // Head fields are forced to zero while the queue is empty
  assign o_mem_addr  = o_mem_we ? q[head].addr  : '0;
  assign o_mem_wdata = o_mem_we ? q[head].wdata : '0;
  assign o_mem_be    = o_mem_we ? q[head].be    : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= i_store_valid & ~legal;
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (enq) begin
      q[tail] <= al;
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load filter / LUI writeback path. Sits in the MEM stage between the pipeline and the data memory write port. Each store is aligned into a word address, byte enables and lane-replicated write data (SB/SH/SW), then queued in a small FIFO that drains to memory under a valid/ack handshake. The pipeline is stalled only when the queue is full.

## Interface
Parameters:
- BITS_SIZE, 32, data word width; only 32 is supported (4 byte lanes).
- ADDR_SIZE, 32, byte-address width.
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_store_valid  input  1  MEM stage presents a store this cycle.
- i_store_type  input  2  00 SB, 01 SH, 10 SW, 11 reserved.
- i_addr  input  ADDR_SIZE  store byte address (ALU result).
- i_data  input  BITS_SIZE  store data (rt register value).
- o_store_ready  output  1  FIFO can accept an entry (count < DEPTH).
- o_stall  output  1  i_store_valid & ~o_store_ready (combinational).
- o_misaligned  output  1  one-cycle registered pulse for a rejected store.
- o_empty  output  1  FIFO holds no entries.
- o_mem_we  output  1  head entry valid, write requested.
- o_mem_addr  output  ADDR_SIZE  head word address, bits [1:0] = 0.
- o_mem_wdata  output  BITS_SIZE  head lane-replicated data.
- o_mem_be  output  4  head byte enables; bit n enables byte n (bits 8n+7:8n).
- i_mem_ack  input  1  memory accepted the head write this cycle.

## Operation
- Alignment, with a = i_addr[1:0]:
  - SB: be = 1 << a; wdata = {4{i_data[7:0]}}.
  - SH: legal only if a[0] = 0. be = 4'b0011 when a[1] = 0, otherwise 4'b1100; wdata = {2{i_data[15:0]}}.
  - SW: legal only if a = 0. be = 4'b1111; wdata = i_data.
  - Address stored as {i_addr[ADDR_SIZE-1:2], 2'b00}.
- Rejection: a misaligned SH/SW or type 11 is never enqueued, regardless of fullness. o_misaligned = 1 for exactly the next cycle.
- Enqueue condition: i_store_valid & o_store_ready & legal. The entry {addr, wdata, be} is written at tail; the tail pointer increments and wraps mod DEPTH.
- Dequeue condition: o_mem_we & i_mem_ack. The head pointer increments and wraps mod DEPTH.
- Memory outputs are driven from head registers. When empty: o_mem_we = 0 and addr/wdata/be = 0.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- o_store_ready uses the current count only. When full, a same-cycle dequeue does not admit a new store; the store is stalled one cycle.
- i_mem_ack while empty is ignored.
- Entries drain strictly in FIFO order.
- State: head pointer, tail pointer, count (0..DEPTH), o_misaligned register, DEPTH entry registers.

## Timing
- Reset (asynchronous, active-low) sets:
  - count = 0 and both pointers = 0;
  - o_misaligned = 0, o_mem_we = 0, o_mem_addr/o_mem_wdata/o_mem_be = 0;
  - o_store_ready = 1, o_empty = 1, o_stall = 0.
- Reset mid-operation discards all queued stores; no write is issued afterwards.
- Latency: a store accepted at edge N is on o_mem_* from cycle N+1 when the queue was empty. Otherwise it appears after the earlier entries are acked.
- A head with o_mem_we = 1 holds addr/wdata/be stable until the cycle i_mem_ack = 1.
- o_misaligned rises on the edge after the offending request and falls on the following edge.
- o_stall has zero latency (same cycle) so the hazard unit can freeze IF/ID/EX/MEM.

## Test plan
- SB, addr 0x0000_0103, data 0x0000_00AB, ack tied 1 -> next cycle o_mem_we = 1, addr 0x100, be 1000, wdata 0xABABABAB; o_empty = 1 one cycle later.
- SH, addr 0x0000_0202, data 0xFFFF_1234 -> addr 0x200, be 1100, wdata 0x12341234. SH at 0x200 -> be 0011.
- SW at 0x101, then type 11 at 0x100 -> neither enqueued, o_misaligned pulses for 1 cycle after each, o_empty stays 1, o_mem_we stays 0.
- DEPTH = 2 with ack held 0: SW 0x10 = 0x11111111, SW 0x14 = 0x22222222, SW 0x18 = 0x33333333. Third store sees o_store_ready = 0 and o_stall = 1. Ack one cycle -> head becomes 0x14, third store accepted the cycle after. Writes drain in order 0x10, 0x14, 0x18.
- Count = 1 with enqueue and ack in the same cycle -> count stays 1, o_mem_* shows the new entry next cycle.
- Two entries queued, i_reset low mid-cycle -> o_mem_we = 0 and o_empty = 1 immediately. After release, no write from the old entries ever appears.
